// File: rtl/lod_k_stage_pkg.sv
// Constants shared by the approximate-multiplier stages: operand width, index width
// and the width of the zero-result counter.
package lod_k_stage_pkg;

  localparam int unsigned AmWidth        = 16;
  localparam int unsigned AmLog2Width    = 4;
  localparam int unsigned AmZeroCntWidth = 16;

endpackage

// File: rtl/lod_priority.sv
// Leading-one detector: index of the most-significant set bit, the operand with that
// bit cleared, and a flag for an all-zero operand (index and residue are then zero).
module lod_priority
  import lod_k_stage_pkg::*;
#(
  parameter int unsigned WIDTH      = AmWidth,
  parameter int unsigned LOG2_WIDTH = AmLog2Width
) (
  input  logic [WIDTH-1:0]      operand_i,
  output logic [LOG2_WIDTH-1:0] k_o,
  output logic [WIDTH-1:0]      residue_o,
  output logic                  zero_o
);

  always_comb begin
    k_o    = '0;
    zero_o = 1'b1;
    // Ascending scan: the last set bit seen is the most significant one.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (operand_i[i]) begin
        k_o    = LOG2_WIDTH'(i);
        zero_o = 1'b0;
      end
    end
    residue_o = operand_i;
    if (!zero_o) begin
      residue_o[k_o] = 1'b0;
    end
  end

endmodule

// File: rtl/lod_k_stage.sv
// Two-stage leading-one stage of the approximate multiplier: S1 holds the operand pair,
// S2 holds the leading-one indices, residues and zero flag, with valid/ready flow control.
module lod_k_stage
  import lod_k_stage_pkg::*;
#(
  parameter int unsigned WIDTH      = AmWidth,
  parameter int unsigned LOG2_WIDTH = AmLog2Width
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [WIDTH-1:0]          A,
  input  logic [WIDTH-1:0]          B,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [LOG2_WIDTH-1:0]     KA,
  output logic [LOG2_WIDTH-1:0]     KB,
  output logic [WIDTH-1:0]          RES_A,
  output logic [WIDTH-1:0]          RES_B,
  output logic                      ZERO,
  output logic [AmZeroCntWidth-1:0] ZERO_CNT
);

  logic                      s1_valid_q;
  logic [WIDTH-1:0]          a_q, b_q;
  logic                      out_valid_q;
  logic [LOG2_WIDTH-1:0]     ka_q, kb_q;
  logic [WIDTH-1:0]          res_a_q, res_b_q;
  logic                      zero_q;
  logic [AmZeroCntWidth-1:0] zero_cnt_q, zero_cnt_d;

  logic                      s2_ready, s1_load, s2_load;
  logic [LOG2_WIDTH-1:0]     ka_d, kb_d;
  logic [WIDTH-1:0]          res_a_d, res_b_d;
  logic                      zero_a, zero_b;

  lod_priority #(
    .WIDTH      (WIDTH),
    .LOG2_WIDTH (LOG2_WIDTH)
  ) u_lod_a (
    .operand_i (a_q),
    .k_o       (ka_d),
    .residue_o (res_a_d),
    .zero_o    (zero_a)
  );

  lod_priority #(
    .WIDTH      (WIDTH),
    .LOG2_WIDTH (LOG2_WIDTH)
  ) u_lod_b (
    .operand_i (b_q),
    .k_o       (kb_d),
    .residue_o (res_b_d),
    .zero_o    (zero_b)
  );

  // Each stage may load when empty or when its contents leave on the same edge.
  always_comb begin
    s2_ready = !out_valid_q || OUT_READY;
    IN_READY = !s1_valid_q || s2_ready;
    s1_load  = IN_VALID && IN_READY;
    s2_load  = s1_valid_q && s2_ready;
    zero_cnt_d = zero_cnt_q;
    if (out_valid_q && OUT_READY && zero_q && (zero_cnt_q != '1)) begin
      zero_cnt_d = zero_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      ka_q        <= '0;
      kb_q        <= '0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      zero_q      <= 1'b0;
      zero_cnt_q  <= '0;
    end else begin
      if (IN_READY) begin
        s1_valid_q <= IN_VALID;
      end
      if (s1_load) begin
        a_q <= A;
        b_q <= B;
      end
      if (s2_ready) begin
        out_valid_q <= s1_valid_q;
      end
      if (s2_load) begin
        ka_q    <= ka_d;
        kb_q    <= kb_d;
        res_a_q <= res_a_d;
        res_b_q <= res_b_d;
        zero_q  <= zero_a || zero_b;
      end
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign KA        = ka_q;
  assign KB        = kb_q;
  assign RES_A     = res_a_q;
  assign RES_B     = res_b_q;
  assign ZERO      = zero_q;
  assign ZERO_CNT  = zero_cnt_q;

endmodule

// File: tb/tb_lod_k_stage.sv
// Bench for lod_k_stage: directed literal cases plus randomized traffic against a
// queue-based model of the accepted pairs.
module tb_lod_k_stage;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [3:0]  KA, KB;
  logic [15:0] RES_A, RES_B;
  logic        ZERO;
  logic [15:0] ZERO_CNT;

  int errors = 0;
  int checks = 0;

  lod_k_stage dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .KA        (KA),
    .KB        (KB),
    .RES_A     (RES_A),
    .RES_B     (RES_B),
    .ZERO      (ZERO),
    .ZERO_CNT  (ZERO_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: K = floor(log2(x)), residue = x - 2^K; zero operand gives K=0, residue=0.
  function automatic void lod_ref(input logic [15:0] x, output int k, output int res);
    int v;
    k = 0;
    res = 0;
    if (x != 0) begin
      v = int'(x);
      while (v > 1) begin
        v = v / 2;
        k++;
      end
      res = int'(x) - (1 << k);
    end
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          acc_edge;
  } pair_t;

  pair_t q[$];
  int    edge_cnt = 1;
  int    mcnt = 0;

  // Model: pairs in acceptance order; the head is visible once an edge has passed since
  // it was accepted. Two pairs in flight means both stages are full.
  always @(negedge CLK) begin
    logic exp_ready, exp_valid;
    int ka, kb, ra, rb;
    exp_ready = (q.size() < 2) || OUT_READY;
    exp_valid = (q.size() > 0) && (edge_cnt - q[0].acc_edge >= 1);
    check("in_ready", 32'(IN_READY), 32'(exp_ready));
    check("out_valid", 32'(OUT_VALID), 32'(exp_valid));
    check("zero_cnt", 32'(ZERO_CNT), 32'(mcnt));
    if (exp_valid) begin
      lod_ref(q[0].a, ka, ra);
      lod_ref(q[0].b, kb, rb);
      check("ka", 32'(KA), 32'(ka));
      check("kb", 32'(KB), 32'(kb));
      check("res_a", 32'(RES_A), 32'(ra));
      check("res_b", 32'(RES_B), 32'(rb));
      check("zero", 32'(ZERO), 32'((q[0].a == 0) || (q[0].b == 0)));
    end
    if (!RST_N) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (exp_valid && OUT_READY) begin
        if (((q[0].a == 0) || (q[0].b == 0)) && mcnt < 65535) mcnt++;
        void'(q.pop_front());
      end
      if (IN_VALID && exp_ready) q.push_back('{a: A, b: B, acc_edge: edge_cnt + 1});
    end
    edge_cnt++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic r);
    IN_VALID  = v;
    A         = a;
    B         = b;
    OUT_READY = r;
  endtask

  initial begin
    logic [15:0] pa[4];
    int          ek[4];
    int          idx, oidx, k, r;
    logic        acc;

    pa = '{16'h0003, 16'h0030, 16'h0300, 16'h3000};
    ek = '{1, 5, 9, 13};

    // Pin the reference model itself.
    lod_ref(16'h00F3, k, r);
    check("model_k_f3", 32'(k), 32'd7);
    check("model_r_f3", 32'(r), 32'h73);
    lod_ref(16'h8000, k, r);
    check("model_k_8000", 32'(k), 32'd15);

    repeat (2) tick();
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_zero_cnt", 32'(ZERO_CNT), 32'd0);
    check("rst_ka", 32'(KA), 32'd0);
    check("rst_res_b", 32'(RES_B), 32'd0);
    RST_N = 1'b1;
    #1;
    check("ready_after_rst", 32'(IN_READY), 32'd1);

    // Extremes of the operand range.
    drive(1, 16'h0001, 16'h8000, 1);
    tick();
    drive(0, 16'h0, 16'h0, 1);
    tick();
    check("d1_valid", 32'(OUT_VALID), 32'd1);
    check("d1_ka", 32'(KA), 32'd0);
    check("d1_kb", 32'(KB), 32'd15);
    check("d1_res_a", 32'(RES_A), 32'd0);
    check("d1_res_b", 32'(RES_B), 32'd0);
    check("d1_zero", 32'(ZERO), 32'd0);

    drive(1, 16'h00F3, 16'h0005, 1);
    tick();
    drive(0, 16'h0, 16'h0, 1);
    tick();
    check("d2_ka", 32'(KA), 32'd7);
    check("d2_res_a", 32'(RES_A), 32'h73);
    check("d2_kb", 32'(KB), 32'd2);
    check("d2_res_b", 32'(RES_B), 32'd1);

    drive(1, 16'h0000, 16'h0005, 1);
    tick();
    drive(0, 16'h0, 16'h0, 1);
    tick();
    check("d3_zero", 32'(ZERO), 32'd1);
    check("d3_ka", 32'(KA), 32'd0);
    check("d3_res_a", 32'(RES_A), 32'd0);
    check("d3_kb", 32'(KB), 32'd2);
    check("d3_res_b", 32'(RES_B), 32'd1);
    check("d3_cnt_before", 32'(ZERO_CNT), 32'd0);
    tick();
    check("d3_cnt_after", 32'(ZERO_CNT), 32'd1);
    repeat (2) tick();

    // Backpressure: only two pairs fit while the output is stalled.
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1, pa[idx], 16'h0001, 0);
      #1;
      acc = IN_READY;
      tick();
      if (acc) idx++;
    end
    #1;
    check("bp_accepted", 32'(idx), 32'd2);
    check("bp_in_ready", 32'(IN_READY), 32'd0);
    oidx = 0;
    for (int c = 0; c < 20 && oidx < 4; c++) begin
      if (idx < 4) drive(1, pa[idx], 16'h0001, 1);
      else drive(0, 16'h0, 16'h0, 1);
      #1;
      acc = IN_READY;
      if (OUT_VALID) begin
        check("bp_order_ka", 32'(KA), 32'(ek[oidx]));
        oidx++;
      end
      tick();
      if (acc && idx < 4) idx++;
    end
    check("bp_all_out", 32'(oidx), 32'd4);

    // Reset with two zero pairs in flight: neither may be delivered.
    drive(1, 16'h0, 16'h0, 0);
    repeat (2) tick();
    drive(0, 16'h0, 16'h0, 0);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    #1;
    check("mr_out_valid", 32'(OUT_VALID), 32'd0);
    check("mr_zero_cnt", 32'(ZERO_CNT), 32'd0);
    check("mr_zero", 32'(ZERO), 32'd0);
    drive(0, 16'h0, 16'h0, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mr_no_out", 32'(OUT_VALID), 32'd0);
    end
    check("mr_cnt_hold", 32'(ZERO_CNT), 32'd0);

    // Saturation of the zero-result counter.
    drive(1, 16'h0, 16'h1234, 1);
    repeat (65540) tick();
    check("sat_cnt", 32'(ZERO_CNT), 32'hFFFF);
    drive(0, 16'h0, 16'h0, 1);
    repeat (3) tick();
    check("sat_hold", 32'(ZERO_CNT), 32'hFFFF);

    // Randomized traffic with random backpressure and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      A         = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom() >> $urandom_range(0, 31));
      B         = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom() >> $urandom_range(0, 31));
      OUT_READY = ($urandom_range(0, 2) != 0);
      RST_N     = ($urandom_range(0, 299) != 0);
      tick();
    end
    RST_N = 1'b1;
    drive(0, 16'h0, 16'h0, 1);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lod_k_stage.md
LOD_K_STAGE -- requirements
Module: lod_k_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter LOG2_WIDTH, default 4, width of each K index (= log2 WIDTH).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port IN_VALID  input  1  operand pair A/B valid.
REQ-006 SHALL have port IN_READY  output  1  stage accepts a pair this cycle.
REQ-007 SHALL have port A  input  WIDTH  unsigned operand A.
REQ-008 SHALL have port B  input  WIDTH  unsigned operand B.
REQ-009 SHALL have port OUT_VALID  output  1  result valid.
REQ-010 SHALL have port OUT_READY  input  1  downstream shift/multiply stage accepts the result.
REQ-011 SHALL have port KA  output  LOG2_WIDTH  index of the leading one of A.
REQ-012 SHALL have port KB  output  LOG2_WIDTH  index of the leading one of B.
REQ-013 SHALL have port RES_A  output  WIDTH  A with its leading one cleared.
REQ-014 SHALL have port RES_B  output  WIDTH  B with its leading one cleared.
REQ-015 SHALL have port ZERO  output  1  A==0 or B==0 for this result.
REQ-016 SHALL have port ZERO_CNT  output  16  saturating count of ZERO results delivered.

Function
REQ-017 SHALL be a two-stage pipeline: S1 registers A/B; S2 registers KA/KB/RES_A/RES_B/ZERO from S1 contents.
REQ-018 SHALL have latency 2: a pair accepted in cycle n appears with OUT_VALID=1 at cycle n+2 if no backpressure.
REQ-019 SHALL sustain one accepted pair per cycle while OUT_READY=1.
REQ-020 SHALL count a transfer when VALID and READY are both high on the same rising edge; no other condition.
REQ-021 SHALL let each stage load when it is empty or its contents transfer out in the same cycle; IN_READY = S1 empty or S1 advancing.
REQ-022 SHALL keep OUT_VALID and all result outputs stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 SHALL not drop, duplicate or reorder pairs under any backpressure pattern.
REQ-024 SHALL give K = position of the most-significant set bit (bit 0 = LSB).
REQ-025 SHALL give RES = operand XOR (1 << K), zero-extended to WIDTH.
REQ-026 SHALL, for a zero operand, output K=0 and RES=0 for that operand and assert ZERO.
REQ-027 SHALL compute K and RES for the non-zero operand normally when only one operand is zero.
REQ-028 SHALL increment ZERO_CNT by 1 on each output transfer with ZERO=1, and saturate at 16'hFFFF.
REQ-029 SHALL ignore A/B when IN_VALID=0 and when IN_READY=0.

Reset
REQ-030 SHALL, while RST_N=0 at a rising edge, clear both stages: OUT_VALID=0, KA=KB=0, RES_A=RES_B=0, ZERO=0, ZERO_CNT=0.
REQ-031 SHALL drive IN_READY=1 in the first cycle after reset release.
REQ-032 SHALL discard in-flight pairs on reset mid-operation, with no output transfer for them after release.

Structure
REQ-033 SHALL take WIDTH/LOG2_WIDTH defaults and the ZERO_CNT width from the shared approximate-multiplier constants include, used by the downstream shift stage too.
REQ-034 SHALL use one combinational sub-module lod_priority (operand in; K, residue, zero flag out), instantiated twice in S2 input logic.
REQ-035 SHALL have no combinational path from A/B to any output; IN_READY may depend combinationally on OUT_READY.

Verification
REQ-036 SHALL cover: A=16'h0001, B=16'h8000, OUT_READY=1 -> 2 cycles later KA=0, KB=15, RES_A=0, RES_B=0, ZERO=0.
REQ-037 SHALL cover: A=16'h00F3, B=16'h0005 -> KA=7, RES_A=16'h0073, KB=2, RES_B=16'h0001.
REQ-038 SHALL cover: A=0, B=5 -> ZERO=1, KA=0, RES_A=0, KB=2, RES_B=1, ZERO_CNT 0->1 on transfer.
REQ-039 SHALL cover: 4 back-to-back pairs with OUT_READY=0 for 4 cycles -> IN_READY drops after 2 accepted; all 4 emerge in order once OUT_READY=1.
REQ-040 SHALL cover: RST_N=0 for one cycle with 2 pairs in flight -> OUT_VALID=0 next cycle, ZERO_CNT=0, neither pair delivered.
REQ-041 SHALL cover: 65536 ZERO transfers -> ZERO_CNT holds 16'hFFFF.
